// File: rtl/mult_pkg.sv
// =============================================================================
// Module      : mult_pkg
// Description : Shared constants for the shift-add multiplier sequencer.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mult_shift_add_dp.sv
// =============================================================================
// Module      : mult_shift_add_dp
// Description : Shift-add multiplier datapath (accumulator, multiplicand,
//               multiplier, adder). MULT_EARLY_EXIT_EN enables early finish.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mult_shift_add_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               cnt_last,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic [2*WIDTH-1:0] acc,
    output logic               step_last
);

    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (load) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, src_a};
            r_mplier <= src_b;
        end else if (step) begin
            // Multiplicand is zero-extended to 2*WIDTH, so the sum never overflows.
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
        end
    end

    assign acc = r_acc;

`ifdef MULT_EARLY_EXIT_EN
    // Once no multiplier bits remain above bit 0, this is the last useful step.
    assign step_last = cnt_last | (r_mplier[WIDTH-1:1] == '0);
`else
    assign step_last = cnt_last;
`endif

endmodule

`default_nettype wire

// File: rtl/mult_sequencer.sv
// =============================================================================
// Module      : mult_sequencer
// Description : Iterative unsigned multiplier controller with HI/LO registers
//               and pipeline stall. Optional macro: MULT_EARLY_EXIT_EN.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mult_enable,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             sf_read,
    input  logic             sfmux_high,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] sf_out,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] w_acc;
    logic               w_load;
    logic               w_step;
    logic               w_busy;
    logic               w_done;
    logic               w_cnt_last;
    logic               w_step_last;

    mult_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .step      (w_step),
        .cnt_last  (w_cnt_last),
        .src_a     (src_a),
        .src_b     (src_b),
        .acc       (w_acc),
        .step_last (w_step_last)
    );

    assign w_cnt_last = (r_cnt == c_cnt_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (mult_enable) w_next_state = ST_RUN;
            ST_RUN:  if (w_step_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load = 1'b0;
        w_step = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_IDLE: w_load = mult_enable;
            ST_RUN: begin
                w_step = 1'b1;
                w_busy = 1'b1;
            end
            ST_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_load) begin
            r_cnt <= '0;
        end else if (w_step) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // HI/LO only move on the DONE cycle, so reads during RUN see the old result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_done) begin
            r_hi <= w_acc[2*WIDTH-1:WIDTH];
            r_lo <= w_acc[WIDTH-1:0];
        end
    end

    assign hi     = r_hi;
    assign lo     = r_lo;
    assign sf_out = sfmux_high ? r_hi : r_lo;
    assign busy   = w_busy;
    assign done   = w_done;
    assign stall  = w_busy & (sf_read | mult_enable);

endmodule

`default_nettype wire
